// File: rtl/pack_fifo.sv
// Byte-to-halfword packer feeding a small word FIFO. Pairs of bytes form
// {high, low} words; in_last flushes a lone byte as an "odd" word.
module pack_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_vld,
    input  logic        in_last,
    output logic [15:0] out_data,
    output logic        out_odd,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic        full,
    output logic        ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic        odd;
        logic [15:0] word;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    hold;
    logic          hold_valid;

    entry_t        form;
    logic          form_vld;
    logic          push;
    logic          pop;

    // NOTE: every signal gets a default first so this block can never infer a latch.
    always_comb begin
        form     = '0;
        form_vld = 1'b0;
        if (in_vld) begin
            if (hold_valid) begin
                form_vld  = 1'b1;
                form.odd  = 1'b0;
                form.word = {in_data, hold};
            end else if (in_last) begin
                form_vld  = 1'b1;
                form.odd  = 1'b1;
                form.word = {8'h00, in_data};
            end
        end
    end

    assign out_vld  = (count != '0);
    assign full     = (count == DEPTH_CNT);
    assign pop      = out_vld & out_rdy;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a word.
    assign push     = form_vld & (~full | pop);
    assign out_data = out_vld ? mem[rd_ptr].word : 16'h0000;
    assign out_odd  = out_vld ? mem[rd_ptr].odd  : 1'b0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            hold_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (in_vld) begin
                if (hold_valid) begin
                    hold_valid <= 1'b0;
                end else if (!in_last) begin
                    hold       <= in_data;
                    hold_valid <= 1'b1;
                end
            end
            if (form_vld && !push) begin
                ovf <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; stale entries are masked by out_vld.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= form;
        end
    end

endmodule

// File: tb/tb_pack_fifo.sv
// Self-checking bench for pack_fifo: a vector table for single-word traffic plus
// directed fill/overflow, full push-and-pop, and mid-stream reset sequences.
module tb_pack_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_vld;
    logic        in_last;
    logic [15:0] out_data;
    logic        out_odd;
    logic        out_vld;
    logic        out_rdy;
    logic        full;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    logic [16:0] exp_q [$];

    typedef struct {
        logic        vld;
        logic [7:0]  data;
        logic        last;
        logic        exp_vld;
        logic        exp_odd;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    pack_fifo #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_last  (in_last),
        .out_data (out_data),
        .out_odd  (out_odd),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .full     (full),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        in_vld  = 1'b1;
        in_data = d;
        in_last = l;
        step();
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        out_rdy = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (!out_vld) break;
            step();
        end
        check("drain_done", {31'b0, out_vld}, 32'd0);
        check("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    // Scoreboard: every accepted head word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", {15'b0, out_odd, out_data}, 32'h1_ffff);
            end else begin
                check("sb_word", {15'b0, out_odd, out_data}, {15'b0, exp_q.pop_front()});
                n_pops++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pops_before;

        // Reset with inputs active: they must be ignored.
        rst_n   = 1'b0;
        in_vld  = 1'b1;
        in_last = 1'b1;
        in_data = 8'h99;
        out_rdy = 1'b1;
        step();
        step();
        in_vld  = 1'b0;
        in_last = 1'b0;
        in_data = 8'h00;
        rst_n   = 1'b1;
        step();
        check("rst_out_vld", {31'b0, out_vld}, 32'd0);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        check("rst_out_data", {16'b0, out_data}, 32'h0);
        check("rst_out_odd", {31'b0, out_odd}, 32'd0);

        // Single-word traffic with the consumer always ready.
        vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 16'hB2A1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 8'h5C, 1'b1, 1'b1, 1'b1, 16'h005C};
        vecs[4]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 16'h2211};
        vecs[6]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 16'h4433};
        vecs[10] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 16'h0055};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000};

        out_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_vld  = vecs[i].vld;
            in_data = vecs[i].data;
            in_last = vecs[i].last;
            if (vecs[i].exp_vld) exp_q.push_back({vecs[i].exp_odd, vecs[i].exp_data});
            step();
            check($sformatf("vec%0d_out_vld", i), {31'b0, out_vld}, {31'b0, vecs[i].exp_vld});
            check($sformatf("vec%0d_out_data", i), {16'b0, out_data}, {16'b0, vecs[i].exp_data});
            check($sformatf("vec%0d_out_odd", i), {31'b0, out_odd}, {31'b0, vecs[i].exp_odd});
        end
        in_vld  = 1'b0;
        in_last = 1'b0;
        check("table_queue_empty", exp_q.size(), 32'd0);

        // Fill with the consumer stalled; the fifth word {09,08} is dropped.
        out_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 1 && k < 9) exp_q.push_back({1'b0, 8'(k), 8'(k - 1)});
            send(8'(k), 1'b0);
            if (k == 5) check("fill_not_full_3", {31'b0, full}, 32'd0);
            if (k == 7) begin
                check("fill_full_4", {31'b0, full}, 32'd1);
                check("fill_no_ovf_yet", {31'b0, ovf}, 32'd0);
            end
        end
        check("ovf_set", {31'b0, ovf}, 32'd1);
        check("stall_head_stable", {16'b0, out_data}, 32'h0100);
        check("stall_still_full", {31'b0, full}, 32'd1);
        drain(10);
        check("ovf_sticky", {31'b0, ovf}, 32'd1);

        // Full FIFO, pair completes in the same cycle as a pop.
        do_reset();
        step();
        check("rst2_ovf", {31'b0, ovf}, 32'd0);
        out_rdy = 1'b0;
        for (int k = 16; k < 24; k++) begin
            if (k % 2 == 1) exp_q.push_back({1'b0, 8'(k), 8'(k - 1)});
            send(8'(k), 1'b0);
        end
        check("pp_full_before", {31'b0, full}, 32'd1);
        send(8'h18, 1'b0);
        exp_q.push_back(17'h0_1918);
        pops_before = n_pops;
        out_rdy = 1'b1;
        send(8'h19, 1'b0);
        check("pp_full_kept", {31'b0, full}, 32'd1);
        check("pp_no_ovf", {31'b0, ovf}, 32'd0);
        drain(10);
        check("pp_pop_count", n_pops - pops_before, 32'd5);

        // Reset mid-stream: three queued words and a held byte are discarded.
        out_rdy = 1'b0;
        for (int k = 0; k < 7; k++) send(8'(8'h30 + k), 1'b0);
        check("mid_full_before", {31'b0, full}, 32'd0);
        do_reset();
        check("mid_rst_out_vld", {31'b0, out_vld}, 32'd0);
        check("mid_rst_ovf", {31'b0, ovf}, 32'd0);
        out_rdy = 1'b1;
        send(8'hEE, 1'b0);
        check("mid_ee_held", {31'b0, out_vld}, 32'd0);
        exp_q.push_back(17'h0_FFEE);
        send(8'hFF, 1'b0);
        check("mid_ffee_data", {16'b0, out_data}, 32'hFFEE);
        check("mid_ffee_odd", {31'b0, out_odd}, 32'd0);
        step();
        check("mid_alone", {31'b0, out_vld}, 32'd0);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pack_fifo.md
PACK_FIFO -- requirements
Module: pack_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, the number of 16-bit word entries; legal values are powers of two and at least 2.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: synchronous reset, active-low.
REQ-004 SHALL provide port in_data, input, 8 bits: byte from the upstream stage's 8-bit result bus.
REQ-005 SHALL provide port in_vld, input, 1 bit: in_data is valid this cycle; there is no input backpressure.
REQ-006 SHALL provide port in_last, input, 1 bit: qualified by in_vld; marks the final byte of a burst and forces a flush.
REQ-007 SHALL provide port out_data, output, 16 bits: head word, {high byte, low byte}.
REQ-008 SHALL provide port out_odd, output, 1 bit: head word carries only its low byte; the high byte is 8'h00.
REQ-009 SHALL provide port out_vld, output, 1 bit: the FIFO is non-empty.
REQ-010 SHALL provide port out_rdy, input, 1 bit: the consumer accepts the head word when out_vld and out_rdy are both 1.
REQ-011 SHALL provide port full, output, 1 bit: the FIFO holds DEPTH entries.
REQ-012 SHALL provide port ovf, output, 1 bit: sticky overflow flag; it records that a formed word was dropped.

Function
REQ-013 SHALL keep a byte hold register with a hold_valid flag.
- Byte accepted with hold empty and in_last=0: the byte is stored in the hold register.
- Byte accepted with hold full: the word {in_data, hold} is formed with odd=0, and the hold register is cleared.
- Byte accepted with hold empty and in_last=1: the word {8'h00, in_data} is formed with odd=1.
REQ-014 SHALL push a formed word in the same cycle it forms, when count<DEPTH or a pop occurs in that cycle.
REQ-015 SHALL drop a formed word that cannot be pushed; when that happens, ovf is set, and the hold register still updates per REQ-013.
REQ-016 SHALL store a 17-bit entry {odd, word}, using read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-017 SHALL maintain count, of width log2(DEPTH)+1 bits.
- Push only: count+1.
- Pop only: count-1.
- Push and pop in the same cycle: count is unchanged.
REQ-018 SHALL pop when out_vld=1 and out_rdy=1; when out_vld=0, out_rdy is ignored.
REQ-019 SHALL drive out_vld = (count!=0) and full = (count==DEPTH), both from registered state.
REQ-020 SHALL drive out_data and out_odd to 0 whenever out_vld=0.
REQ-021 SHALL have a latency of one cycle: a word formed in cycle N into an empty FIFO appears with out_vld=1 in cycle N+1.
REQ-022 SHALL hold out_data and out_odd stable while out_vld=1 and out_rdy=0.
REQ-023 SHALL allow a push into a full FIFO in a cycle with a concurrent pop; in that case, ovf is not set and full stays 1.
REQ-024 SHALL treat in_last with in_vld=0 as a no-op.
REQ-025 SHALL keep a lone held byte waiting indefinitely until the next byte or an in_last arrives; there is no timeout.

Reset
REQ-026 SHALL, when rst_n=0 at a rising clk edge, clear count, both pointers, hold_valid and ovf.
REQ-027 SHALL, in the cycle after reset, drive out_vld=0, full=0, ovf=0, out_data=16'h0000 and out_odd=0.
REQ-028 SHALL ignore in_vld, in_last and out_rdy while rst_n=0.
REQ-029 SHALL, on reset mid-operation, discard all stored and held data, with no partial word emitted afterwards.
REQ-030 SHALL leave the storage array contents unreset; they are unobservable because of REQ-020.

Verification
REQ-031 Pair packing:
- Stimulus: bytes 8'hA1 then 8'hB2, in_last=0, out_rdy=1.
- Response: the cycle after 8'hB2, out_vld=1, out_data=16'hB2A1, out_odd=0; the cycle after that, out_vld=0.
REQ-032 Odd flush:
- Stimulus: byte 8'h5C with in_last=1, hold empty.
- Response: next cycle out_data=16'h005C, out_odd=1.
- Follow-up: a held 8'h11 followed by 8'h22 with in_last=1 yields 16'h2211 with out_odd=0.
REQ-033 Fill and overflow, with DEPTH=4 and out_rdy=0:
- Stimulus: 10 bytes 8'h00..8'h09.
- Response: full=1 after the 4th word; the 5th word {09,08} is dropped and ovf=1.
- Drain with out_rdy=1: words 0100, 0302, 0504, 0706, in order.
REQ-034 Push and pop while full:
- Stimulus: FIFO full, out_rdy=1, and a pair completes in the same cycle.
- Response: count stays 4, ovf stays 0, and the new word exits last with pointer wrap verified.
REQ-035 Reset mid-stream:
- Stimulus: 3 words queued plus a held byte, then rst_n=0 for 1 cycle.
- Response: out_vld=0 and ovf=0 after reset; the next pair 8'hEE, 8'hFF yields 16'hFFEE alone.
